// File: rtl/itof_pipe.sv
// itof_pipe: three-stage pipelined signed 32-bit integer to IEEE-754 single
// precision converter with round-to-nearest-even and valid/ready handshakes
// on both sides. Stalls collapse bubbles; throughput is one result per cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rstn       asynchronous active-low reset
//   in_valid   x holds a conversion request
//   in_ready   stage 1 can accept this cycle (combinational)
//   x          two's-complement integer operand
//   out_valid  y holds a result (registered)
//   out_ready  consumer accepts y this cycle
//   y          float result {sign, exp[7:0], mant[22:0]} (registered)
module itof_pipe (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y
);

   localparam int unsigned W       = 32;
   localparam int unsigned LZ_W    = 6;
   localparam int unsigned SIG_W   = 24;
   localparam int unsigned EXP_W   = 8;
   // Biased exponent of 2^31 minus one; the implicit one of the rounded
   // significand adds the missing one back during packing.
   localparam int unsigned EXP_TOP_M1 = 157;

   // Stage valids and advance terms
   logic v1;
   logic v2;
   logic adv1;
   logic adv2;
   logic adv3;

   // Stage 1 registers: sign and magnitude
   logic          s1_sign;
   logic [W-1:0]  s1_mag;

   // Stage 2 registers: normalized magnitude
   logic            s2_sign;
   logic            s2_zero;
   logic [LZ_W-1:0] s2_lz;
   logic [W-1:0]    s2_norm;

   // Combinational stage results
   logic [W-1:0]     mag_d;
   logic [LZ_W-1:0]  lz_d;
   logic [W-1:0]     norm_d;
   logic             zero_d;
   logic [SIG_W-1:0] sig;
   logic             guard;
   logic             sticky;
   logic             inc;
   logic [SIG_W:0]   sum;
   logic [EXP_W-1:0] exp_m1;
   logic [30:0]      y_mag;
   logic [W-1:0]     y_d;

   // Stall chain: a stage advances when its successor advances or it is empty
   always_comb begin
      adv3     = out_ready | ~out_valid;
      adv2     = adv3 | ~v2;
      adv1     = adv2 | ~v1;
      in_ready = adv1;
   end

   // Stage 1 datapath: magnitude of the two's-complement operand
   always_comb begin
      mag_d = x[31] ? (~x + 32'd1) : x;
   end

   // Stage 2 datapath: leading-zero count (highest set bit wins) and shift
   always_comb begin
      lz_d = LZ_W'(32);
      for (int i = 0; i < 32; i++) begin
         if (s1_mag[i]) begin
            lz_d = LZ_W'(31 - i);
         end
      end
      norm_d = s1_mag << lz_d;
      zero_d = (s1_mag == '0);
   end

   // Stage 3 datapath: round to nearest even and pack.
   // The rounded significand is added on top of {exp-1, 0}: its implicit
   // one bumps the exponent back up, and a rounding carry-out (sum = 2^24)
   // bumps it once more while clearing the mantissa field.
   always_comb begin
      sig    = s2_norm[31:8];
      guard  = s2_norm[7];
      sticky = |s2_norm[6:0];
      inc    = guard & (sticky | sig[0]);
      sum    = {1'b0, sig} + (SIG_W + 1)'(inc);
      exp_m1 = EXP_W'(EXP_TOP_M1) - EXP_W'(s2_lz);
      y_mag  = {exp_m1, 23'd0} + 31'(sum);
      y_d    = s2_zero ? '0 : {s2_sign, y_mag};
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
      end else begin
         if (adv1) begin
            v1 <= in_valid;
         end
         if (adv2) begin
            v2 <= v1;
         end
         if (adv3) begin
            out_valid <= v2;
            // y keeps its last value while no result is presented
            if (v2) begin
               y <= y_d;
            end
         end
      end
   end

   // Datapath registers, contents are don't-care while their stage is empty
   always_ff @(posedge clk) begin
      if (adv1) begin
         s1_sign <= x[31];
         s1_mag  <= mag_d;
      end
      if (adv2) begin
         s2_sign <= s1_sign;
         s2_zero <= zero_d;
         s2_lz   <= lz_d;
         s2_norm <= norm_d;
      end
   end

endmodule
